alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// - Sequences single ALU operations for the control unit. Latches the opcode and A/B operands, drives ALU_32bit
//   through a setup/enable/capture cycle, then returns the result.
// - Owns the integer condition-code register {N,Z,V,C}. It sources the ALU carry-in from C and updates the flags on cc-setting opcodes.
// - Sits between the decode/control FSM and the ALU_32bit instance.
// PARAMETERS
// - WIDTH       32  operand/result width
// - OPW         6   ALU opcode width
// - EXEC_CYCLES 1   cycles alu_enable is held high before capture (legal range 1..15)
// PORTS
// - clk          in   1      single clock; all state updates on rising edge
// - reset        in   1      synchronous, active-high reset
// - req_valid    in   1      operation request
// - req_ready    out  1      sequencer can accept a request
// - req_opcode   in   OPW    ALU opcode; bit4 = S (set cc), bit3 = use carry-in
// - req_a        in   WIDTH  operand A
// - req_b        in   WIDTH  operand B
// - resp_valid   out  1      result available
// - resp_ready   in   1      consumer accepts result
// - resp_result  out  WIDTH  captured ALU result
// - resp_flags   out  4      ALU {N,Z,V,C} captured with the result; valid even when S=0
// - alu_a        out  WIDTH  to ALU A_in
// - alu_b        out  WIDTH  to ALU B_in
// - alu_opcode   out  OPW    to ALU opcode
// - alu_carry    out  1      to ALU carry
// - alu_enable   out  1      to ALU ALUE
// - alu_result   in   WIDTH  from ALU result
// - alu_n, alu_z, alu_v, alu_c  in  1 each  from ALU flag outputs
// - psr_we       in   1      external cc write (WRPSR-style)
// - psr_wdata    in   4      {N,Z,V,C} to write
// - psr_nzvc     out  4      current condition codes {N,Z,V,C}
// - busy         out  1      high in any state other than IDLE
// BEHAVIOUR
// - Reset values: state=IDLE, req_ready=1, resp_valid=0, alu_enable=0, alu_a/alu_b/alu_opcode=0, alu_carry=0,
//   resp_result=0, resp_flags=0, psr_nzvc=4'b0000, busy=0.
// - FSM has four states: IDLE, SETUP, EXEC, DONE.
// - IDLE: req_ready=1. On req_valid, latch opcode/A/B into alu_* and go to SETUP.
// - SETUP (1 cycle): alu_enable=0 while operands settle. alu_carry = opcode[3] ? psr_nzvc[0] : 0, frozen at the
//   SETUP entry value. Then go to EXEC.
// - EXEC: alu_enable=1 for exactly EXEC_CYCLES cycles, counted by a 4-bit down-counter. On the last EXEC cycle:
//   - capture alu_result into resp_result and {alu_n,alu_z,alu_v,alu_c} into resp_flags;
//   - if opcode[4]=1, also load the same flags into psr_nzvc;
//   - go to DONE.
// - DONE: alu_enable=0, resp_valid=1. On resp_ready, go to IDLE. No new request is accepted in DONE.
// - alu_enable is low outside EXEC.
// - Latency from the accept edge to resp_valid is 1 + EXEC_CYCLES cycles, i.e. 2 cycles at the default.
// - Back-to-back operations are spaced at least EXEC_CYCLES+3 cycles apart.
// - A carry chain sees C as written by the previous S=1 op, because flags update before DONE.
// - psr_we is honoured in any state. If it coincides with an S=1 capture, psr_we wins and the ALU flags are still
//   reported on resp_flags.
// - S=0 ops never modify psr_nzvc.
// - Request and operands are sampled only in IDLE. Changes to req_* while busy are ignored.
// - reset mid-operation: next cycle is IDLE with every output at its reset value, and psr_nzvc is cleared.
// - EXEC_CYCLES outside 1..15 is rejected at elaboration (generate-time $error).
// STRUCTURE
// - Shared package alu_pkg holds:
//   - localparams OP_S_BIT=4, OP_CARRY_BIT=3, FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0;
//   - state encoding typedef seq_state_t {IDLE,SETUP,EXEC,DONE};
//   - opcode constants ADD=6'b000000, ADDcc=6'b010000, ADDX=6'b001000, ADDXcc=6'b011000, SUB=6'b000100,
//     SUBcc=6'b010100, SUBXcc=6'b011100, AND=6'b000001, SLL=6'b100101.
// - One natural sub-module: cc_reg. It holds the 4-bit NZVC register with write-priority mux (psr_we > ALU capture)
//   and synchronous clear.
// - ALU_32bit is instantiated by the parent, not inside this block.
// TESTING
// - Bench pairs the sequencer with ALU_32bit; EXEC_CYCLES=1 unless stated.
// - ADDcc 0x00000001+0x00000001 -> resp_result=0x00000002, resp_flags=0000, psr_nzvc=0000; resp_valid 2 cycles
//   after accept.
// - ADDXcc 0xffffffff+0x00000001 with C=0 -> result=0x00000000, psr Z=1, C=1. A following ADDX 0x1+0x1 sees
//   alu_carry=1 -> result 0x00000003, psr unchanged.
// - SUBcc 0x00000001-0x00000002 -> result=0xffffffff, N=1. A following AND (S=0) 0x11110000&0x11111111 -> result
//   0x11110000, psr_nzvc holds N=1.
// - resp_ready held low 5 cycles in DONE -> resp_valid and resp_result stable; req_ready=0 and a second req_valid
//   is not accepted until DONE exits.
// - psr_we=1, psr_wdata=4'b1010 on the ADDcc capture cycle -> psr_nzvc=1010, resp_flags shows ALU flags.
//   Separately, reset asserted in EXEC (EXEC_CYCLES=4) -> IDLE next cycle, alu_enable=0, psr_nzvc=0000.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode fields, flag positions, sequencer states and opcode constants.
package alu_pkg;
    localparam int OP_S_BIT     = 4;
    localparam int OP_CARRY_BIT = 3;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, DONE} seq_state_t;

    localparam logic [5:0] ADD    = 6'b000000;
    localparam logic [5:0] ADDcc  = 6'b010000;
    localparam logic [5:0] ADDX   = 6'b001000;
    localparam logic [5:0] ADDXcc = 6'b011000;
    localparam logic [5:0] SUB    = 6'b000100;
    localparam logic [5:0] SUBcc  = 6'b010100;
    localparam logic [5:0] SUBXcc = 6'b011100;
    localparam logic [5:0] AND    = 6'b000001;
    localparam logic [5:0] SLL    = 6'b100101;
endpackage

// File: rtl/alu_op_sequencer_cc_reg.sv
// cc_reg: NZVC condition-code register; an external write beats an ALU capture.
module cc_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] wdata,
    input  logic       cap,
    input  logic [3:0] cap_data,
    output logic [3:0] nzvc
);
    always_ff @(posedge clk)
        nzvc <= reset ? 4'b0000 : we ? wdata : cap ? cap_data : nzvc;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one ALU op through setup/enable/capture and owns the NZVC register.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int OPW         = 6,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OPW-1:0]   req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    output logic             alu_carry,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             psr_we,
    input  logic [3:0]       psr_wdata,
    output logic [3:0]       psr_nzvc,
    output logic             busy
);
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
        $error("EXEC_CYCLES must be in 1..15");
    end

    seq_state_t state;
    logic [3:0] cnt;
    logic       cap;

    assign cap = (state == EXEC) && (cnt == 4'd0) && alu_opcode[OP_S_BIT];

    cc_reg u_cc (
        .clk      (clk),
        .reset    (reset),
        .we       (psr_we),
        .wdata    (psr_wdata),
        .cap      (cap),
        .cap_data ({alu_n, alu_z, alu_v, alu_c}),
        .nzvc     (psr_nzvc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_flags  <= 4'b0000;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            alu_carry   <= 1'b0;
            alu_enable  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    alu_a      <= req_a;
                    alu_b      <= req_b;
                    alu_opcode <= req_opcode;
                    // carry-in is taken once, on entry to SETUP, and held for the whole op
                    alu_carry  <= req_opcode[OP_CARRY_BIT] & psr_nzvc[FLAG_C];
                    req_ready  <= 1'b0;
                    busy       <= 1'b1;
                    state      <= SETUP;
                end
                SETUP: begin
                    alu_enable <= 1'b1;
                    cnt        <= 4'(EXEC_CYCLES - 1);
                    state      <= EXEC;
                end
                EXEC: if (cnt == 4'd0) begin
                    resp_result <= alu_result;
                    resp_flags  <= {alu_n, alu_z, alu_v, alu_c};
                    alu_enable  <= 1'b0;
                    resp_valid  <= 1'b1;
                    state       <= DONE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the sequencer against a behavioural ALU_32bit stand-in.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk = 0, reset = 1, reset2 = 1;
    always #5 clk = ~clk;

    logic        req_valid = 0, resp_ready = 0, psr_we = 0;
    logic [5:0]  req_opcode = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic [3:0]  psr_wdata = 0;
    logic        req_ready, resp_valid, alu_carry, alu_enable, busy;
    logic        alu_n, alu_z, alu_v, alu_c;
    logic [31:0] resp_result, alu_a, alu_b, alu_result;
    logic [3:0]  resp_flags, psr_nzvc;
    logic [5:0]  alu_opcode;

    logic        req_valid2 = 0, resp_ready2 = 0, psr_we2 = 0;
    logic [5:0]  req_opcode2 = 0;
    logic [31:0] req_a2 = 0, req_b2 = 0;
    logic [3:0]  psr_wdata2 = 0;
    logic        req_ready2, resp_valid2, alu_carry2, alu_enable2, busy2;
    logic        alu_n2, alu_z2, alu_v2, alu_c2;
    logic [31:0] resp_result2, alu_a2, alu_b2, alu_result2;
    logic [3:0]  resp_flags2, psr_nzvc2;
    logic [5:0]  alu_opcode2;

    int checks = 0, errors = 0;

    // {N,Z,V,C,result}; C is carry-out for add and borrow for subtract
    function automatic logic [35:0] alu_model(logic [5:0] op, logic [31:0] a, logic [31:0] b, logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic v, c;
        s = '0; v = 0; c = 0;
        if (op[2:0] == 3'b000) begin
            s = {1'b0, a} + {1'b0, b} + 33'(cin);
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (op[2:0] == 3'b100) begin
            s = {1'b0, a} - {1'b0, b} - 33'(cin);
            r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end else if (op[2:0] == 3'b001) r = a & b;
        else if (op[2:0] == 3'b101) r = a << b[4:0];
        else r = '0;
        return {r[31], r == 32'd0, v, c, r};
    endfunction

    assign {alu_n, alu_z, alu_v, alu_c, alu_result} = alu_model(alu_opcode, alu_a, alu_b, alu_carry);
    assign {alu_n2, alu_z2, alu_v2, alu_c2, alu_result2} = alu_model(alu_opcode2, alu_a2, alu_b2, alu_carry2);

    alu_op_sequencer #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flags(resp_flags), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_carry(alu_carry), .alu_enable(alu_enable), .alu_result(alu_result),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .psr_we(psr_we), .psr_wdata(psr_wdata), .psr_nzvc(psr_nzvc), .busy(busy)
    );

    alu_op_sequencer #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_opcode(req_opcode2), .req_a(req_a2), .req_b(req_b2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_result(resp_result2),
        .resp_flags(resp_flags2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2),
        .alu_carry(alu_carry2), .alu_enable(alu_enable2), .alu_result(alu_result2),
        .alu_n(alu_n2), .alu_z(alu_z2), .alu_v(alu_v2), .alu_c(alu_c2),
        .psr_we(psr_we2), .psr_wdata(psr_wdata2), .psr_nzvc(psr_nzvc2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op1(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [31:0] res, input logic [3:0] fl, input logic [3:0] psr);
        int n;
        req_opcode = op; req_a = a; req_b = b; req_valid = 1;
        step();
        req_valid = 0;
        chk({tag, "_setup_en"}, alu_enable, 0);
        chk({tag, "_carry"}, alu_carry, cin);
        n = 0;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        chk({tag, "_result"}, resp_result, res);
        chk({tag, "_flags"}, resp_flags, fl);
        chk({tag, "_psr"}, psr_nzvc, psr);
        resp_ready = 1;
        step();
        resp_ready = 0;
        chk({tag, "_idle_ready"}, {req_ready, resp_valid, busy}, 3'b100);
    endtask

    initial begin
        int n;
        step(); step();
        reset = 0; reset2 = 0;
        chk("rst_ctrl", {req_ready, resp_valid, alu_enable, alu_carry, busy}, 5'b10000);
        chk("rst_psr", psr_nzvc, 0);
        chk("rst_result", {resp_flags, resp_result}, 0);
        chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);

        op1("addcc",  ADDcc,  32'h1,        32'h1,        0, 32'h2,        4'b0000, 4'b0000);
        op1("addxcc", ADDXcc, 32'hffffffff, 32'h1,        0, 32'h0,        4'b0101, 4'b0101);
        op1("addx",   ADDX,   32'h1,        32'h1,        1, 32'h3,        4'b0000, 4'b0101);
        op1("subcc",  SUBcc,  32'h1,        32'h2,        0, 32'hffffffff, 4'b1001, 4'b1001);
        op1("and",    AND,    32'h11110000, 32'h11111111, 0, 32'h11110000, 4'b0000, 4'b1001);
        op1("sll",    SLL,    32'h1,        32'h4,        0, 32'h10,       4'b0000, 4'b1001);

        // hold DONE while another request is offered
        req_opcode = ADDcc; req_a = 32'h5; req_b = 32'h3; req_valid = 1;
        step();
        req_a = 32'h77; req_b = 32'h99;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {resp_valid, req_ready, busy}, 3'b101);
            chk("hold_result", resp_result, 32'h8);
            chk("hold_opnd", alu_a, 32'h5);
            step();
        end
        req_valid = 0; resp_ready = 1;
        step();
        resp_ready = 0;
        chk("hold_exit", {req_ready, resp_valid, busy}, 3'b100);
        chk("hold_no_accept", alu_a, 32'h5);
        chk("hold_psr", psr_nzvc, 4'b0000);

        // external write on the capture edge beats the ALU flags
        req_opcode = ADDcc; req_a = 32'hffffffff; req_b = 32'h1; req_valid = 1;
        step();
        req_valid = 0;
        step();
        chk("we_exec_en", alu_enable, 1);
        psr_we = 1; psr_wdata = 4'b1010;
        step();
        psr_we = 0;
        chk("we_valid", resp_valid, 1);
        chk("we_flags", resp_flags, 4'b0101);
        chk("we_psr", psr_nzvc, 4'b1010);
        resp_ready = 1;
        step();
        resp_ready = 0;

        // EXEC_CYCLES=4 latency, then reset mid-EXEC
        req_opcode2 = ADDcc; req_a2 = 32'h1; req_b2 = 32'h1; req_valid2 = 1;
        step();
        req_valid2 = 0;
        n = 0;
        while (!resp_valid2 && n < 20) begin
            step();
            n++;
        end
        chk("x4_latency", n, 5);
        chk("x4_result", resp_result2, 32'h2);
        resp_ready2 = 1;
        step();
        resp_ready2 = 0;
        psr_we2 = 1; psr_wdata2 = 4'b1111;
        step();
        psr_we2 = 0;
        chk("x4_psr_we", psr_nzvc2, 4'b1111);
        req_opcode2 = ADDcc; req_valid2 = 1;
        step();
        req_valid2 = 0;
        step(); step();
        chk("x4_in_exec", {alu_enable2, busy2, resp_valid2}, 3'b110);
        reset2 = 1;
        step();
        reset2 = 0;
        chk("x4_rst_ctrl", {req_ready2, resp_valid2, alu_enable2, alu_carry2, busy2}, 5'b10000);
        chk("x4_rst_psr", psr_nzvc2, 4'b0000);
        chk("x4_rst_data", {resp_flags2, resp_result2}, 0);
        chk("x4_rst_alu", {alu_opcode2, alu_a2, alu_b2}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
